// File: rtl/door_lock_pkg.sv
// Shared keypad/door-lock definitions: key codes, keypad states and the
// door-lock state encodings used by the downstream FSM.
package door_lock_pkg;

   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;

   typedef enum logic [1:0] {
      KP_IDLE    = 2'd0,
      KP_ENTRY   = 2'd1,
      KP_LOCKOUT = 2'd2
   } kp_state_e;

   typedef enum logic [1:0] {
      DL_LOCKED    = 2'd0,
      DL_CHECKING  = 2'd1,
      DL_UNLOCKED  = 2'd2,
      DL_ALARM     = 2'd3
   } dl_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/door_lock_timer.sv
// Up-counter shared by the entry timeout and the lockout period.
// load sets the count to 1 (the loading cycle is the first elapsed cycle).
module door_lock_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = W'(1);
      else if (clr)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == term);

endmodule

// File: rtl/door_lock_keypad.sv
// Keypad code-entry front end producing ps_start/ps_end/err pulses.
// Define KEYPAD_LOCKOUT_EN to add fail counting and the LOCKOUT state.
module door_lock_keypad
   import door_lock_pkg::*;
#(
   parameter int                    CODE_LEN       = 4,
   parameter logic [4*CODE_LEN-1:0] PASSWORD       = 16'h1234,
   parameter int                    TIMEOUT_CYCLES = 5000,
   parameter int                    MAX_FAIL       = 3,
   parameter int                    LOCKOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       ps_start,
   output logic       ps_end,
   output logic       err,
   output logic [3:0] digit_cnt,
   output logic       locked_out
);

   localparam int         BUF_W = 4*CODE_LEN;
   localparam int         TMR_W = $clog2(max_int(TIMEOUT_CYCLES, LOCKOUT_CYCLES) + 1);
   localparam logic [3:0] CL    = 4'(CODE_LEN);

   kp_state_e        state_q, state_d;
   logic [BUF_W-1:0] buf_q, buf_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ps_start_q, ps_start_d;
   logic             ps_end_q, ps_end_d;
   logic             err_q, err_d;
   logic             tmr_load, tmr_clr, tmr_tc;
   logic [TMR_W-1:0] tmr_term;
   logic             key_digit, key_star, key_hash;

   assign key_digit = key_valid && (key_code <= 4'd9);
   assign key_star  = key_valid && (key_code == KEY_STAR);
   assign key_hash  = key_valid && (key_code == KEY_HASH);

`ifdef KEYPAD_LOCKOUT_EN
   localparam int              FAIL_W = $clog2(MAX_FAIL + 1);
   localparam logic [FAIL_W-1:0] MF   = FAIL_W'(MAX_FAIL);
   logic [FAIL_W-1:0] fail_q, fail_d;
   logic              locked_q, locked_d;
`else
   // Lockout parameters have no function without the lockout feature.
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(MAX_FAIL);
`endif

   assign tmr_term = (state_q == KP_LOCKOUT) ? TMR_W'(LOCKOUT_CYCLES - 1)
                                             : TMR_W'(TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      ps_start_d = 1'b0;
      ps_end_d   = 1'b0;
      err_d      = 1'b0;
      tmr_load   = 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
      fail_d     = fail_q;
`endif
      case (state_q)
         KP_IDLE: begin
            if (key_star) begin
               state_d    = KP_ENTRY;
               buf_d      = '0;
               ovf_d      = 1'b0;
               cnt_d      = '0;
               ps_start_d = 1'b1;
               tmr_load   = 1'b1;
            end
         end
         KP_ENTRY: begin
            if (key_digit) begin
               tmr_load = 1'b1;
               if (cnt_q < CL) begin
                  buf_d = BUF_W'({buf_q, key_code});
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (key_star) begin
               tmr_load = 1'b1;
               buf_d    = '0;
               ovf_d    = 1'b0;
               cnt_d    = '0;
            end else if (key_hash) begin
               state_d = KP_IDLE;
               cnt_d   = '0;
               if (cnt_q == CL && !ovf_q && buf_q == PASSWORD) begin
                  ps_end_d = 1'b1;
`ifdef KEYPAD_LOCKOUT_EN
                  fail_d   = '0;
`endif
               end else begin
                  err_d = 1'b1;
`ifdef KEYPAD_LOCKOUT_EN
                  if (fail_q != MF) fail_d = fail_q + FAIL_W'(1);
                  if (fail_d == MF) begin
                     state_d  = KP_LOCKOUT;
                     tmr_load = 1'b1;
                  end
`endif
               end
            end else if (tmr_tc) begin
               // Only a cycle with no accepted key can expire the entry.
               err_d   = 1'b1;
               state_d = KP_IDLE;
               cnt_d   = '0;
            end
         end
`ifdef KEYPAD_LOCKOUT_EN
         KP_LOCKOUT: begin
            if (tmr_tc) begin
               state_d = KP_IDLE;
               fail_d  = '0;
            end
         end
`endif
         default: state_d = KP_IDLE;
      endcase
   end

   assign tmr_clr = (state_d == KP_IDLE);

   door_lock_timer #(.W(TMR_W)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .clr  (tmr_clr),
      .term (tmr_term),
      .tc   (tmr_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= KP_IDLE;
         buf_q      <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         ps_start_q <= 1'b0;
         ps_end_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         ps_start_q <= ps_start_d;
         ps_end_q   <= ps_end_d;
         err_q      <= err_d;
      end
   end

`ifdef KEYPAD_LOCKOUT_EN
   assign locked_d = (state_d == KP_LOCKOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         fail_q   <= fail_d;
         locked_q <= locked_d;
      end
   end

   assign locked_out = locked_q;
`else
   assign locked_out = 1'b0;
`endif

   assign ps_start  = ps_start_q;
   assign ps_end    = ps_end_q;
   assign err       = err_q;
   assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_door_lock_keypad.sv
// Randomized + directed bench for door_lock_keypad against a queue-based
// reference model; lockout scenario runs when KEYPAD_LOCKOUT_EN is defined.
module tb_door_lock_keypad;
   import door_lock_pkg::*;

   localparam int          CODE_LEN = 4;
   localparam int          TMO      = 5000;
   localparam int          MAXF     = 3;
   localparam int          LOCKC    = 50000;
   localparam logic [15:0] PW       = 16'h1234;
`ifdef KEYPAD_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       ps_start, ps_end, err, locked_out;
   logic [3:0] digit_cnt;

   door_lock_keypad dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .ps_start   (ps_start),
      .ps_end     (ps_end),
      .err        (err),
      .digit_cnt  (digit_cnt),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int obs_start = 0, obs_end = 0, obs_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   // Reference model: mode 0 idle, 1 entry, 2 lockout; digits kept in a queue.
   int m_mode, m_since, m_fail, m_lock;
   int m_dig[$];
   bit m_ovf;
   bit e_start, e_end, e_err;

   function automatic int code_val();
      int v = 0;
      foreach (m_dig[i]) v = v*16 + m_dig[i];
      return v;
   endfunction

   function automatic logic [3:0] pw_digit(input int i);
      logic [15:0] p = PW;
      return 4'(p >> (4*(CODE_LEN-1-i)));
   endfunction

   task automatic model_reset();
      m_mode = 0; m_since = 0; m_fail = 0; m_lock = 0; m_ovf = 0;
      m_dig.delete();
      e_start = 0; e_end = 0; e_err = 0;
   endtask

   task automatic model_step(input bit kv, input logic [3:0] kc);
      bit acc;
      e_start = 0; e_end = 0; e_err = 0;
      acc = kv && (kc <= 4'd11);
      case (m_mode)
         0: if (kv && kc == KEY_STAR) begin
               m_mode = 1; m_dig.delete(); m_ovf = 0; m_since = 1; e_start = 1;
            end
         1: if (acc) begin
               m_since = 1;
               if (kc <= 4'd9) begin
                  if (m_dig.size() < CODE_LEN) m_dig.push_back(int'(kc));
                  else m_ovf = 1;
               end else if (kc == KEY_STAR) begin
                  m_dig.delete(); m_ovf = 0;
               end else begin
                  m_mode = 0;
                  if (m_dig.size() == CODE_LEN && !m_ovf && code_val() == int'(PW)) begin
                     e_end = 1; m_fail = 0;
                  end else begin
                     e_err = 1;
                     if (m_fail < MAXF) m_fail++;
                     if (LOCK_EN && m_fail == MAXF) begin m_mode = 2; m_lock = 1; end
                  end
               end
            end else if (m_since == TMO-1) begin
               e_err = 1; m_mode = 0;
            end else m_since++;
         default: if (m_lock == LOCKC-1) begin m_mode = 0; m_fail = 0; end
                  else m_lock++;
      endcase
   endtask

   task automatic cyc(input bit kv, input logic [3:0] kc);
      logic [7:0] ev;
      @(negedge clk);
      key_valid = kv;
      key_code  = kc;
      model_step(kv, kc);
      @(posedge clk);
      #1;
      ev = {e_start, e_end, e_err, (m_mode == 2), (m_mode == 1) ? 4'(m_dig.size()) : 4'd0};
      chk("cyc_outs", 32'({ps_start, ps_end, err, locked_out, digit_cnt}), 32'(ev));
      if (ps_start) obs_start++;
      if (ps_end)   obs_end++;
      if (err)      obs_err++;
   endtask

   task automatic press(input logic [3:0] k);
      cyc(1'b1, k);
      cyc(1'b0, 4'h0);
   endtask

   task automatic press_r(input logic [3:0] k);
      cyc(1'b1, k);
      repeat ($urandom_range(0, 3)) cyc(1'b0, 4'h0);
   endtask

   task automatic good_code();
      press(KEY_STAR);
      for (int i = 0; i < CODE_LEN; i++) press(pw_digit(i));
      press(KEY_HASH);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      key_valid = 1'b0;
      #1;
      chk("rst_async", 32'({ps_start, ps_end, err, locked_out, digit_cnt}), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic rand_entry(input bit force_ok);
      int kind;
      kind = force_ok ? 0 : int'($urandom_range(0, 5));
      press_r(KEY_STAR);
      for (int i = 0; i < CODE_LEN; i++) begin
         logic [3:0] d;
         d = pw_digit(i);
         if (kind == 1 && $urandom_range(0, 1) == 1) d = 4'($urandom_range(0, 9));
         if (kind == 2 && $urandom_range(0, 2) == 0) press_r(4'($urandom_range(12, 15)));
         press_r(d);
      end
      if (kind == 3) press_r(4'($urandom_range(0, 9)));
      if (kind == 4) begin press_r(KEY_STAR); press_r(pw_digit(0)); end
      if (kind == 5) begin
         for (int j = 0; j < 6; j++) begin
            logic [3:0] k;
            k = 4'($urandom_range(0, 14));
            if (k == KEY_HASH) k = 4'hF;
            press_r(k);
         end
      end
      press_r(KEY_HASH);
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, e0, r0, n, lat;
      model_reset();
      do_reset();

      // 1: correct code
      s0 = obs_start; e0 = obs_end; r0 = obs_err;
      cyc(1'b1, KEY_STAR);
      chk("t1_start_pulse", 32'(ps_start), 32'd1);
      cyc(1'b0, 4'h0);
      for (int i = 0; i < CODE_LEN; i++) press(pw_digit(i));
      cyc(1'b1, KEY_HASH);
      chk("t1_end_pulse", 32'(ps_end), 32'd1);
      cyc(1'b0, 4'h0);
      chk("t1_end_one_cycle", 32'(ps_end), 32'd0);
      chk("t1_cnt_idle", 32'(digit_cnt), 32'd0);
      chk("t1_counts", 32'({8'(obs_start - s0), 8'(obs_end - e0), 8'(obs_err - r0)}), 32'h010100);

      // 2: wrong code then correct code
      e0 = obs_end; r0 = obs_err;
      press(KEY_STAR); press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(KEY_HASH);
      chk("t2_wrong", 32'({8'(obs_end - e0), 8'(obs_err - r0)}), 32'h0001);
      good_code();
      chk("t2_right", 32'({8'(obs_end - e0), 8'(obs_err - r0)}), 32'h0101);

      // 3: overflow, then clear-and-retry within one entry
      r0 = obs_err; e0 = obs_end;
      press(KEY_STAR);
      for (int i = 0; i < CODE_LEN; i++) press(pw_digit(i));
      press(4'd5);
      chk("t3_cnt_hold", 32'(digit_cnt), 32'd4);
      press(KEY_HASH);
      chk("t3_ovf_err", 32'({8'(obs_end - e0), 8'(obs_err - r0)}), 32'h0001);
      s0 = obs_start; e0 = obs_end;
      press(KEY_STAR); press(4'd9); press(KEY_STAR);
      chk("t3_cnt_cleared", 32'(digit_cnt), 32'd0);
      for (int i = 0; i < CODE_LEN; i++) press(pw_digit(i));
      press(KEY_HASH);
      chk("t3_single_start", 32'({8'(obs_start - s0), 8'(obs_end - e0)}), 32'h0101);

      // 4: timeout latency, then a key landing in the expiry cycle
      cyc(1'b1, KEY_STAR); cyc(1'b1, 4'd1); cyc(1'b1, 4'd2);
      n = 1; lat = 0;
      while (lat == 0 && n < TMO + 20) begin
         cyc(1'b0, 4'h0); n++;
         if (err) lat = n;
      end
      chk("t4_tmo_latency", 32'(lat), 32'(TMO));
      r0 = obs_err;
      cyc(1'b1, KEY_STAR); cyc(1'b1, 4'd1); cyc(1'b1, 4'd2);
      repeat (TMO - 2) cyc(1'b0, 4'h0);
      cyc(1'b1, 4'd3);
      chk("t4_key_wins", 32'({8'(obs_err - r0), 4'h0, digit_cnt}), 32'h0003);
      n = 1; lat = 0;
      while (lat == 0 && n < TMO + 20) begin
         cyc(1'b0, 4'h0); n++;
         if (err) lat = n;
      end
      chk("t4_restart_latency", 32'(lat), 32'(TMO));

      // 5: lockout after repeated failures
      if (LOCK_EN) begin
         good_code();
         for (int f = 0; f < MAXF; f++) begin
            press(KEY_STAR); press(4'd7); press(KEY_HASH);
         end
         chk("t5_locked", 32'(locked_out), 32'd1);
         s0 = obs_start;
         press(KEY_STAR);
         chk("t5_no_start", 32'(obs_start - s0), 32'd0);
         n = 1 + 1 + 2;  // '#' sample cycle, its gap, and the '*' press
         while (locked_out && n < LOCKC + 50) begin cyc(1'b0, 4'h0); n++; end
         chk("t5_lock_len", 32'(n), 32'(LOCKC));
         e0 = obs_end;
         good_code();
         chk("t5_after_lock", 32'(obs_end - e0), 32'd1);
      end

      // 6: async reset mid-entry
      press(KEY_STAR); press(4'd1); press(4'd2);
      chk("t6_cnt_before", 32'(digit_cnt), 32'd2);
      do_reset();
      e0 = obs_end;
      good_code();
      chk("t6_after_rst", 32'(obs_end - e0), 32'd1);

      // Randomized entries
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 4) == 0) press_r(4'($urandom_range(0, 15)));
         rand_entry(LOCK_EN && m_fail >= MAXF - 1);
      end
      repeat (4) cyc(1'b0, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
